// File: rtl/pc_fetch.sv
// Program counter and fetch request generator.
// Handles stall, wait states, and branch/exception redirects.
module pc_fetch #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                STEP      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_vec,
    input  logic              gnt,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              req,
    output logic              align_err
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(STEP - 1);
    localparam logic [ADDR_W-1:0] STEP_V   = ADDR_W'(STEP);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              aerr_q, aerr_d;
    logic              pend_v_q, pend_v_d;
    logic              pend_exc_q, pend_exc_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

    logic              adv;
    logic              redir;
    logic [ADDR_W-1:0] raw_tgt;
    logic [ADDR_W-1:0] next_pc;
    logic              misal;

    assign pc        = pc_q;
    assign ce        = ce_q;
    assign align_err = aerr_q;

    // Request: WAIT keeps the outstanding request alive through stall.
    always_comb begin
        req = ce_q & (~stall | (state_q == S_WAIT));
        adv = req & gnt;
    end

    // Next-PC selection: exception, branch, pending, then sequential.
    always_comb begin
        redir   = 1'b1;
        raw_tgt = '0;
        if (exc_req) begin
            raw_tgt = exc_vec;
        end else if (br_taken) begin
            raw_tgt = br_target;
        end else if (pend_v_q) begin
            raw_tgt = pend_tgt_q;
        end else begin
            redir = 1'b0;
        end
        next_pc = redir ? (raw_tgt & ~LOW_MASK) : (pc_q + STEP_V);
        misal   = redir & (|(raw_tgt & LOW_MASK));
    end

    // State, pc and pending-redirect next-state logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = adv ? next_pc : pc_q;
        pend_v_d   = pend_v_q;
        pend_exc_d = pend_exc_q;
        pend_tgt_d = pend_tgt_q;
        unique case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (req && !gnt) state_d = S_WAIT;
            S_WAIT:  if (gnt) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
        if (adv) begin
            pend_v_d   = 1'b0;
            pend_exc_d = 1'b0;
        end else if (exc_req) begin
            pend_v_d   = 1'b1;
            pend_exc_d = 1'b1;
            pend_tgt_d = exc_vec;
        end else if (br_taken && !(pend_v_q && pend_exc_q)) begin
            pend_v_d   = 1'b1;
            pend_exc_d = 1'b0;
            pend_tgt_d = br_target;
        end
        ce_d   = (state_d != S_BOOT);
        aerr_d = adv & misal;
    end

    // Register update with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_VEC;
            ce_q       <= 1'b0;
            aerr_q     <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_exc_q <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ce_q       <= ce_d;
            aerr_q     <= aerr_d;
            pend_v_q   <= pend_v_d;
            pend_exc_q <= pend_exc_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequencing, wait states,
// redirect priority, misalignment, wrap and mid-op reset.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, br_taken, exc_req, gnt;
    logic [31:0] br_target, exc_vec;
    logic [31:0] pc;
    logic        ce, req, align_err;

    logic       br8, gnt8;
    logic [7:0] tgt8;
    logic [7:0] pc8;
    logic       ce8, req8, aerr8;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_fetch #(
        .ADDR_W(32), .RESET_VEC(32'h0), .STEP(4)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .exc_req(exc_req), .exc_vec(exc_vec),
        .gnt(gnt), .pc(pc), .ce(ce), .req(req),
        .align_err(align_err)
    );

    pc_fetch #(
        .ADDR_W(8), .RESET_VEC(8'h0), .STEP(4)
    ) dut8 (
        .clk(clk), .rst(rst), .stall(1'b0),
        .br_taken(br8), .br_target(tgt8),
        .exc_req(1'b0), .exc_vec(8'h0),
        .gnt(gnt8), .pc(pc8), .ce(ce8), .req(req8),
        .align_err(aerr8)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; gnt = 1'b1;
        br_taken = 1'b0; br_target = '0;
        exc_req = 1'b0; exc_vec = '0;
        br8 = 1'b0; tgt8 = '0; gnt8 = 1'b0;
        tick(); tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_ce", {31'b0, ce}, 32'h0);
        chk("rst_req", {31'b0, req}, 32'h0);
        chk("rst_aerr", {31'b0, align_err}, 32'h0);
        rst = 1'b0;
        tick();
        chk("boot_ce", {31'b0, ce}, 32'h1);
        chk("boot_pc", pc, 32'h0);
        chk("boot_req", {31'b0, req}, 32'h1);
        tick(); chk("seq4", pc, 32'h4);
        tick(); chk("seq8", pc, 32'h8);
        tick(); chk("seq12", pc, 32'hC);
        stall = 1'b1;
        #1;
        chk("stall_req", {31'b0, req}, 32'h0);
        chk("stall_ce", {31'b0, ce}, 32'h1);
        tick(); chk("stall_pc", pc, 32'hC);
        stall = 1'b0;
        tick(); chk("seq16", pc, 32'h10);
        gnt = 1'b0; br_taken = 1'b1; br_target = 32'h100;
        tick(); chk("wait_hold1", pc, 32'h10);
        br_taken = 1'b0; stall = 1'b1;
        #1;
        chk("wait_req", {31'b0, req}, 32'h1);
        tick(); chk("wait_hold2", pc, 32'h10);
        gnt = 1'b1; stall = 1'b0;
        tick(); chk("wait_redir", pc, 32'h100);
        tick(); chk("pend_clr", pc, 32'h104);
        exc_req = 1'b1; exc_vec = 32'h80;
        br_taken = 1'b1; br_target = 32'h200;
        tick(); chk("prio_exc", pc, 32'h80);
        exc_req = 1'b0; br_taken = 1'b0;
        tick(); chk("prio_seq", pc, 32'h84);
        stall = 1'b1; exc_req = 1'b1; exc_vec = 32'h300;
        tick(); chk("pexc_hold", pc, 32'h84);
        exc_req = 1'b0; br_taken = 1'b1; br_target = 32'h400;
        tick(); chk("pbr_hold", pc, 32'h84);
        br_taken = 1'b0; stall = 1'b0;
        tick(); chk("pend_exc", pc, 32'h300);
        tick(); chk("pend_exc_seq", pc, 32'h304);
        br_taken = 1'b1; br_target = 32'h102;
        tick();
        chk("mis_pc", pc, 32'h100);
        chk("mis_aerr", {31'b0, align_err}, 32'h1);
        br_taken = 1'b0;
        tick();
        chk("mis_pc2", pc, 32'h104);
        chk("mis_aerr0", {31'b0, align_err}, 32'h0);
        gnt = 1'b0; br_taken = 1'b1; br_target = 32'h500;
        tick(); chk("mrst_wait", pc, 32'h104);
        br_taken = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_ce", {31'b0, ce}, 32'h0);
        chk("mrst_req", {31'b0, req}, 32'h0);
        tick();
        rst = 1'b0; gnt = 1'b1;
        tick();
        chk("mrst_boot_pc", pc, 32'h0);
        chk("mrst_boot_ce", {31'b0, ce}, 32'h1);
        tick(); chk("mrst_nopend", pc, 32'h4);
        br8 = 1'b1; tgt8 = 8'hFC; gnt8 = 1'b1;
        tick(); chk("w8_fc", {24'b0, pc8}, 32'hFC);
        br8 = 1'b0;
        tick();
        chk("w8_wrap", {24'b0, pc8}, 32'h0);
        chk("w8_aerr", {31'b0, aerr8}, 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
